// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and bus constants for the HDMI I2C responder
package i2c_pkg;
  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT
  } state_e;
  localparam logic ACK = 1'b0;
  localparam logic NACK = 1'b1;
  localparam logic [7:0] DEV_ADDR_DEFAULT = 8'h72;
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: synchronizes SCL/SDA and derives edge, START and STOP pulses
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);
  logic [SYNC_STAGES:0] scl_q, scl_d, sda_q, sda_d;
  logic scl_s, scl_h, sda_h;
  always_comb begin
    scl_d = {scl_q[SYNC_STAGES-1:0], scl_in};
    sda_d = {sda_q[SYNC_STAGES-1:0], sda_in};
  end
  // the bus idles high, so reset to 1 to avoid a phantom edge or START
  always_ff @(posedge clk) begin
    scl_q <= rst ? '1 : scl_d;
    sda_q <= rst ? '1 : sda_d;
  end
  assign scl_s = scl_q[SYNC_STAGES-1];
  assign scl_h = scl_q[SYNC_STAGES];
  assign sda = sda_q[SYNC_STAGES-1];
  assign sda_h = sda_q[SYNC_STAGES];
  assign scl_rise = scl_s & ~scl_h;
  assign scl_fall = ~scl_s & scl_h;
  assign start = scl_s & scl_h & sda_h & ~sda;
  assign stop = scl_s & scl_h & ~sda_h & sda;
endmodule

// File: rtl/i2c_hdmi_responder.sv
// i2c_hdmi_responder: I2C target emulating the HDMI transmitter's 8-bit-subaddress register file
module i2c_hdmi_responder
  import i2c_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR = DEV_ADDR_DEFAULT,
  parameter int SYNC_STAGES = 2,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       I2C_SCLK,
  input  logic       I2C_SDAT_IN,
  output logic       I2C_SDAT_OE,
  output logic       oWR_STB,
  output logic [7:0] oWR_ADDR,
  output logic [7:0] oWR_DATA,
  output logic       oBUSY,
  input  logic [7:0] iDBG_ADDR,
  output logic [7:0] oDBG_DATA
);
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sr_q, sr_d, ptr_q, ptr_d, wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic rw_q, rw_d, oe_q, oe_d, stb_q, stb_d;
  logic [7:0] regs_q [256];
  logic sda, scl_rise, scl_fall, start, stop, last;
  logic [7:0] byte_in, ptr_nx, rd_byte;
  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(iCLK), .rst(iRST), .scl_in(I2C_SCLK), .sda_in(I2C_SDAT_IN),
    .sda(sda), .scl_rise(scl_rise), .scl_fall(scl_fall), .start(start), .stop(stop)
  );
  assign byte_in = {sr_q[6:0], sda};
  assign last = cnt_q == 4'd7;
  assign ptr_nx = ptr_q + 8'd1;
  assign rd_byte = regs_q[ptr_q];
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sr_d = sr_q;
    ptr_d = ptr_q;
    rw_d = rw_q;
    oe_d = oe_q;
    stb_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (stop) begin
      state_d = IDLE;
      oe_d = 1'b0;
    end else if (start) begin
      state_d = DEV;
      cnt_d = '0;
      oe_d = 1'b0;
    end else case (state_q)
      DEV, SUB, WDATA: if (scl_rise) begin
        sr_d = byte_in;
        cnt_d = last ? 4'd0 : cnt_q + 4'd1;
        if (last && state_q == DEV) begin
          state_d = byte_in[7:1] == DEV_ADDR[7:1] ? DEV_ACK : WAIT;
          rw_d = byte_in[0];
        end else if (last && state_q == SUB) begin
          state_d = SUB_ACK;
          ptr_d = byte_in;
        end else if (last) begin
          state_d = WDATA_ACK;
          stb_d = 1'b1;
          wr_addr_d = ptr_q;
          wr_data_d = byte_in;
          ptr_d = ptr_nx;
        end
      end
      // first fall pulls SDA low, second fall releases and moves on
      DEV_ACK, SUB_ACK, WDATA_ACK: if (scl_fall) begin
        oe_d = ~oe_q;
        if (oe_q) begin
          state_d = state_q == DEV_ACK ? (rw_q ? RDATA : SUB) : WDATA;
          if (state_q == DEV_ACK && rw_q) begin
            oe_d = ~rd_byte[7];
            sr_d = {rd_byte[6:0], 1'b0};
            cnt_d = 4'd1;
          end
        end
      end
      RDATA: if (scl_fall) begin
        oe_d = cnt_q == 4'd8 ? 1'b0 : ~sr_q[7];
        state_d = cnt_q == 4'd8 ? RACK : RDATA;
        sr_d = {sr_q[6:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
      end
      RACK: if (scl_rise) begin
        state_d = sda == NACK ? WAIT : RDATA;
        if (sda == ACK) begin
          ptr_d = ptr_nx;
          sr_d = regs_q[ptr_nx];
          cnt_d = '0;
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sr_q <= '0;
      ptr_q <= '0;
      rw_q <= 1'b0;
      oe_q <= 1'b0;
      stb_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      regs_q <= '{default: RST_VAL};
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sr_q <= sr_d;
      ptr_q <= ptr_d;
      rw_q <= rw_d;
      oe_q <= oe_d;
      stb_q <= stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      if (stb_d) regs_q[ptr_q] <= byte_in;
    end
  end
  assign I2C_SDAT_OE = oe_q;
  assign oWR_STB = stb_q;
  assign oWR_ADDR = wr_addr_q;
  assign oWR_DATA = wr_data_q;
  assign oBUSY = state_q != IDLE && state_q != WAIT;
  assign oDBG_DATA = regs_q[iDBG_ADDR];
endmodule

// File: tb/tb_i2c_hdmi_responder.sv
// tb_i2c_hdmi_responder: randomized I2C master against a byte-level register model
module tb_i2c_hdmi_responder;
  localparam int Q = 6;
  logic clk = 1'b0, rst = 1'b1, scl_m = 1'b1, sda_m = 1'b1, quiet = 1'b0;
  logic oe, stb, busy, sda_line;
  logic [7:0] wa, wd, dbg_data, dbg_addr = 8'h00;
  logic [7:0] m_regs [256];
  logic [7:0] m_ptr = 8'h00;
  logic [15:0] exp_q [$];
  logic [15:0] e;
  logic [7:0] dq [$];
  logic [7:0] rd [$];
  int vectors = 0, errors = 0;
  int kind, n;
  logic [7:0] sub, dev;
  logic r;

  assign sda_line = sda_m & ~oe;

  i2c_hdmi_responder dut (
    .iCLK(clk), .iRST(rst), .I2C_SCLK(scl_m), .I2C_SDAT_IN(sda_line), .I2C_SDAT_OE(oe),
    .oWR_STB(stb), .oWR_ADDR(wa), .oWR_DATA(wd), .oBUSY(busy),
    .iDBG_ADDR(dbg_addr), .oDBG_DATA(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (!rst) begin
    if (stb) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_stb: got addr %0h data %0h expected no strobe", wa, wd);
      end else begin
        e = exp_q.pop_front();
        chk("wr_stb", {wa, wd}, e);
      end
    end
    if (quiet) chk("idle_oe_busy_stb", {oe, busy, stb}, 0);
  end

  task automatic q_wait;
    repeat (Q) @(negedge clk);
  endtask

  task automatic bit_io(input logic b, output logic rv);
    sda_m = b;
    q_wait;
    scl_m = 1'b1;
    q_wait;
    rv = sda_line;
    q_wait;
    scl_m = 1'b0;
    q_wait;
  endtask

  task automatic start_c;
    quiet = 1'b0;
    sda_m = 1'b1;
    q_wait;
    scl_m = 1'b1;
    q_wait;
    sda_m = 1'b0;
    q_wait;
    scl_m = 1'b0;
    q_wait;
  endtask

  task automatic stop_c;
    sda_m = 1'b0;
    q_wait;
    scl_m = 1'b1;
    q_wait;
    sda_m = 1'b1;
    q_wait;
    q_wait;
    chk("busy_after_stop", busy, 0);
    quiet = 1'b1;
  endtask

  task automatic wbyte(input logic [7:0] b, input logic exp_ack, input string nm);
    logic a;
    for (int i = 7; i >= 0; i--) bit_io(b[i], a);
    bit_io(1'b1, a);
    chk(nm, a, exp_ack);
  endtask

  task automatic rbyte(input logic mack);
    logic a;
    logic [7:0] d;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, a);
      d[i] = a;
    end
    bit_io(mack, a);
    chk("rd_data", d, m_regs[m_ptr]);
    rd.push_back(d);
  endtask

  task automatic do_write(input logic [7:0] dv, input logic [7:0] sa);
    logic hit;
    hit = dv[7:1] == 7'h39;
    start_c;
    wbyte(dv, !hit, "dev_ack");
    chk("busy_after_dev", busy, hit);
    wbyte(sa, !hit, "sub_ack");
    if (hit) m_ptr = sa;
    foreach (dq[i]) begin
      if (hit) begin
        exp_q.push_back({m_ptr, dq[i]});
        m_regs[m_ptr] = dq[i];
        m_ptr++;
      end
      wbyte(dq[i], !hit, "data_ack");
    end
    stop_c;
  endtask

  task automatic do_read(input logic with_sub, input logic [7:0] sa, input int cnt);
    rd.delete();
    start_c;
    if (with_sub) begin
      wbyte(8'h72, 1'b0, "dev_ack");
      wbyte(sa, 1'b0, "sub_ack");
      m_ptr = sa;
      start_c;
    end
    wbyte(8'h73, 1'b0, "rdev_ack");
    for (int i = 0; i < cnt; i++) begin
      rbyte(i == cnt - 1);
      if (i != cnt - 1) m_ptr++;
    end
    stop_c;
  endtask

  task automatic do_abort(input logic [7:0] sa, input int k);
    logic a;
    start_c;
    wbyte(8'h72, 1'b0, "dev_ack");
    wbyte(sa, 1'b0, "sub_ack");
    m_ptr = sa;
    for (int i = 0; i < k; i++) bit_io(1'($urandom_range(0, 1)), a);
    stop_c;
  endtask

  task automatic dbg_chk(input logic [7:0] a);
    dbg_addr = a;
    #1;
    chk("dbg_model", dbg_data, m_regs[a]);
  endtask

  task automatic dbg_lit(input logic [7:0] a, input logic [7:0] v);
    dbg_addr = a;
    #1;
    chk("dbg_literal", dbg_data, v);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    foreach (m_regs[i]) m_regs[i] = 8'h00;
    repeat (4) @(negedge clk);
    chk("reset_outputs", {oe, stb, busy, wa, wd}, 0);
    dbg_lit(8'h41, 8'h00);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    quiet = 1'b1;
    // single write
    dq = {8'h10};
    do_write(8'h72, 8'h41);
    dbg_lit(8'h41, 8'h10);
    // burst with pointer wrap
    dq = {8'hAA, 8'hBB, 8'hCC};
    do_write(8'h72, 8'hFE);
    dbg_lit(8'hFE, 8'hAA);
    dbg_lit(8'hFF, 8'hBB);
    dbg_lit(8'h00, 8'hCC);
    // read through repeated START
    dq = {8'h03, 8'hE0};
    do_write(8'h72, 8'h98);
    do_read(1'b1, 8'h98, 2);
    chk("rd_first", rd[0], 8'h03);
    chk("rd_second", rd[1], 8'hE0);
    // wrong device address
    dq = {8'h55};
    do_write(8'h70, 8'h41);
    dbg_lit(8'h41, 8'h10);
    // STOP mid data byte
    do_abort(8'h41, 4);
    dbg_lit(8'h41, 8'h10);
    // pointer persists into a read with no subaddress
    dq = {8'h12, 8'h34};
    do_write(8'h72, 8'h50);
    dq.delete();
    do_write(8'h72, 8'h50);
    do_read(1'b0, 8'h00, 2);
    chk("rd_persist0", rd[0], 8'h12);
    chk("rd_persist1", rd[1], 8'h34);
    for (int t = 0; t < 20; t++) begin
      kind = $urandom_range(0, 3);
      sub = 8'($urandom);
      n = $urandom_range(1, 4);
      dq.delete();
      for (int i = 0; i < n; i++) dq.push_back(8'($urandom));
      case (kind)
        0: do_write(8'h72, sub);
        1: do_read(1'($urandom_range(0, 1)), sub, n);
        2: begin
          dev = 8'($urandom) & 8'hFE;
          if (dev == 8'h72) dev = 8'h70;
          do_write(dev, sub);
        end
        default: do_abort(sub, $urandom_range(1, 6));
      endcase
      dbg_chk(sub);
      dbg_chk(8'($urandom));
    end
    for (int a = 0; a < 256; a++) dbg_chk(8'(a));
    // reset while the responder drives a 0 data bit
    dq = {8'h0F};
    do_write(8'h72, 8'h30);
    start_c;
    wbyte(8'h72, 1'b0, "dev_ack");
    wbyte(8'h30, 1'b0, "sub_ack");
    start_c;
    wbyte(8'h73, 1'b0, "rdev_ack");
    for (int i = 0; i < 50 && !oe; i++) @(negedge clk);
    chk("oe_driving_zero", oe, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("oe_after_reset", oe, 0);
    rst = 1'b0;
    foreach (m_regs[i]) m_regs[i] = 8'h00;
    m_ptr = 8'h00;
    stop_c;
    for (int a = 0; a < 256; a++) dbg_chk(8'(a));
    dbg_lit(8'h41, 8'h00);
    do_read(1'b0, 8'h00, 1);
    repeat (10) @(negedge clk);
    chk("pending_strobes", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
